// File: rtl/rv32_instr_enc_pkg.sv
// rv32_instr_enc_pkg: shared RV32 encoder types, opcode constants and immediate range helper
package rv32_instr_enc_pkg;
  typedef enum logic [2:0] {
    RV32_TYPE_R,
    RV32_TYPE_I,
    RV32_TYPE_S,
    RV32_TYPE_B,
    RV32_TYPE_U,
    RV32_TYPE_J
  } rv32_type_enum_t;
  typedef logic [31:0] rv32_instr_t;
  typedef logic [31:0] rv32_imm_t;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  // true when imm[31:lsb] are all copies of the sign bit
  function automatic logic sext_ok(input rv32_imm_t imm, input int unsigned lsb);
    rv32_imm_t s;
    s = rv32_imm_t'($signed(imm) >>> lsb);
    return s == '0 || s == '1;
  endfunction
endpackage

// File: rtl/rv32_instr_enc_imm_pack.sv
// rv32_imm_pack: scatters an immediate into its instruction bit positions and flags unrepresentable values
module rv32_imm_pack
  import rv32_instr_enc_pkg::*;
(
  input  rv32_type_enum_t typ_i,
  input  rv32_imm_t       imm_i,
  output rv32_instr_t     bits_o,
  output logic            err_o
);
  always_comb begin
    bits_o = '0;
    err_o  = 1'b0;
    case (typ_i)
      RV32_TYPE_R: ;
      RV32_TYPE_S: begin
        bits_o = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
        err_o  = !sext_ok(imm_i, 11);
      end
      RV32_TYPE_B: begin
        bits_o = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
        err_o  = imm_i[0] || !sext_ok(imm_i, 12);
      end
      RV32_TYPE_U: begin
        bits_o = {imm_i[31:12], 12'b0};
        err_o  = |imm_i[11:0];
      end
      RV32_TYPE_J: begin
        bits_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
        err_o  = imm_i[0] || !sext_ok(imm_i, 20);
      end
      default: begin
        bits_o = {imm_i[11:0], 20'b0};
        err_o  = typ_i != RV32_TYPE_I || !sext_ok(imm_i, 11);
      end
    endcase
  end
endmodule

// File: rtl/rv32_instr_enc.sv
// rv32_instr_enc: two-stage valid/ready encoder packing decoded RV32 fields into an instruction word
module rv32_instr_enc
  import rv32_instr_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  rv32_type_enum_t in_type,
  input  logic [6:0]      in_opcode,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  rv32_imm_t       in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output rv32_instr_t     out_instr,
  output logic            out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);
  rv32_instr_t imm_bits, pack_d, s1_instr_q, s2_instr_q;
  logic imm_err, use_rd, use_rs, use_rs2, use_f7;
  logic s1_valid_q, s1_err_q, s2_valid_q, s2_err_q, s1_adv, s2_adv;
  logic [CNT_W-1:0] enc_q, err_q;
  rv32_imm_pack u_imm_pack (
    .typ_i (in_type),
    .imm_i (in_imm),
    .bits_o(imm_bits),
    .err_o (imm_err)
  );
  // undefined types fall through to the I-type register layout
  assign use_rd  = !(in_type inside {RV32_TYPE_S, RV32_TYPE_B});
  assign use_rs  = !(in_type inside {RV32_TYPE_U, RV32_TYPE_J});
  assign use_rs2 = in_type inside {RV32_TYPE_R, RV32_TYPE_S, RV32_TYPE_B};
  assign use_f7  = in_type == RV32_TYPE_R;
  assign pack_d  = imm_bits | {use_f7 ? in_funct7 : 7'b0, use_rs2 ? in_rs2 : 5'b0,
                               use_rs ? {in_rs1, in_funct3} : 8'b0, use_rd ? in_rd : 5'b0, in_opcode};
  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign enc_count = enc_q;
  assign err_count = err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
      enc_q      <= '0;
      err_q      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_instr_q <= pack_d;
          s1_err_q   <= imm_err;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_instr_q <= s1_instr_q;
          s2_err_q   <= s1_err_q;
        end
      end
      if (out_valid && out_ready) begin
        if (~&enc_q) enc_q <= enc_q + CNT_W'(1);
        if (s2_err_q && ~&err_q) err_q <= err_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: doc/rv32_instr_enc.md
Name: rv32_instr_enc

Overview:
- Instruction encoder: packs decoded RV32 fields (opcode, rd, rs1, rs2, funct3, funct7, 32-bit immediate, format type) into a 32-bit instruction word.
- Inverse of the immediate decode path. Used by the debug/program loader and by the verification scoreboard to build instruction-memory images in hardware.
- Two-stage valid/ready pipeline:
  - S1 registers the range check and bit packing.
  - S2 is the output register, which holds its value under backpressure.

Parameters:
- CNT_W, 16, width of the saturating encoded-instruction and error counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept fields this cycle
- in_type  in  rv32_type_enum_t  format: R/I/S/B/U/J
- in_opcode  in  7  opcode[6:0]
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R only)
- in_imm  in  rv32_imm_t  immediate as full signed/byte value (U: already shifted; B/J: byte offset)
- out_valid  out  1  out_instr valid
- out_ready  in  1  consumer accepts
- out_instr  out  rv32_instr_t  encoded instruction
- out_err  out  1  immediate not representable in in_type; out_instr carries truncated bits
- enc_count  out  CNT_W  instructions delivered (saturating)
- err_count  out  CNT_W  delivered with out_err=1 (saturating)

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): s1_valid=0, s2_valid=0, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0. in_ready is 1 in the first cycle after reset is released.
- Reset asserted mid-operation: all in-flight words are dropped. No output handshake completes during a reset cycle.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Once asserted, out_valid, out_instr and out_err are held stable until the transfer completes.
- Pipeline control:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no combinational path from in_valid).
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle.
- Ordering: strictly in order. No drop or duplicate under any pattern of in_valid/out_ready.
- Packing (S1). bits[6:0]=opcode for every type; the remaining bits per type:
  - R: funct7|rs2|rs1|funct3|rd.
  - I: imm[11:0]|rs1|funct3|rd.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0].
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11].
  - U: imm[31:12]|rd.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd.
  - Undefined enum value: encode as I and set err=1.
- Range check (S1). err=1 when:
  - R: never.
  - I, S: imm[31:11] not all equal.
  - B: imm[0]=1, or imm[31:12] not all equal.
  - U: imm[11:0] != 0.
  - J: imm[0]=1, or imm[31:20] not all equal.
- On error the word is still emitted, with truncated fields and out_err=1.
- Counters: update on the output transfer cycle only.
  - enc_count += 1.
  - err_count += 1 if out_err.
  - Both saturate at 2^CNT_W-1; no wrap.

Decomposition:
- Shared package:
  - rv32_type_enum_t must include RV32_TYPE_R alongside I/S/B/U/J.
  - rv32_instr_t, rv32_imm_t.
  - Opcode constants used by benches: OP_IMM, STORE, BRANCH, LUI, JAL.
- Sub-module rv32_imm_pack: combinational type+imm -> {instr bit contributions, err}. This is the exact inverse of the immediate decoder and is reusable by the scoreboard.

Test Plan:
- I: opcode=0010011, rd=1, rs1=0, f3=0, imm=5 -> out_instr=0x00500093, err=0, out_valid 2 cycles after accept.
- S and B:
  - S: opcode=0100011, rs1=1, rs2=2, f3=010, imm=8 -> 0x0020A423.
  - B: opcode=1100011, rs1=rs2=0, f3=0, imm=0xFFFFFFFC -> 0xFE000EE3.
- U and J:
  - U: opcode=0110111, rd=5, imm=0x12345000 -> 0x123452B7.
  - J: opcode=1101111, rd=1, imm=0x800 -> 0x001000EF.
- Range errors:
  - I with imm=0x800 -> 0x80000093, out_err=1, err_count=1.
  - J with imm=3 -> out_err=1.
  - Clean words leave err_count unchanged.
- Backpressure: out_ready=0, in_valid=1 with 3 distinct words:
  - Exactly 2 are accepted, then in_ready=0.
  - out_instr is held stable while stalled.
  - Raising out_ready delivers all 3 in order, with enc_count=3.
- Reset mid-flight: both stages valid, rst=1 for one cycle -> next cycle out_valid=0, counters=0, in_ready=1, and no stale word is ever delivered.
